// File: rtl/cpu_fetch_pkg.sv
// Shared CPU defines: tag width and the opcodes that end a straight-line
// fetch run because the next PC comes from execute.
package cpu_fetch_pkg;

    localparam int TAG_SIZE = 4;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // True when the instruction's successor is unknown until execute resolves it.
    function automatic logic is_control_transfer(input logic [6:0] opcode);
        return (opcode == OPC_JAL) || (opcode == OPC_JALR) || (opcode == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/cpu_fetch.sv
// Instruction fetch: issues one word read at a time, hands the word to decode
// (buffering it while decode stalls), and parks after a control transfer until
// execute reports the resolved target for that instruction's tag.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// FETCH      | read request outstanding at pc, waiting for i_bus_ready
// HOLD       | word captured in buffer, waiting for decode to accept it
// WAIT_JUMP  | control transfer emitted, waiting for i_jump_tag == o_tag
// GAP        | one idle cycle between an emission/redirect and next FETCH
module cpu_fetch
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_stall,
    output logic                o_bus_request,
    input  logic                i_bus_ready,
    output logic [31:0]         o_bus_address,
    input  logic [31:0]         i_bus_rdata,
    input  logic [TAG_SIZE-1:0] i_jump_tag,
    input  logic [31:0]         i_jump_pc,
    output logic [TAG_SIZE-1:0] o_tag,
    output logic [31:0]         o_instruction,
    output logic [31:0]         o_pc
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_HOLD,
        S_WAIT_JUMP,
        S_GAP
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] buffer;

    logic        emit_valid;
    logic [31:0] emit_word;
    logic        emit_is_jump;

    // pc only moves on the way into GAP, so it doubles as a stable bus address.
    assign o_bus_address = pc;

    // Decide whether this edge hands a word to decode, and which word.
    always_comb begin
        emit_valid   = 1'b0;
        emit_word    = i_bus_rdata;
        emit_is_jump = 1'b0;
        if (state == S_FETCH) begin
            emit_valid = i_bus_ready && !i_stall;
            emit_word  = i_bus_rdata;
        end else if (state == S_HOLD) begin
            emit_valid = !i_stall;
            emit_word  = buffer;
        end
        emit_is_jump = is_control_transfer(emit_word[6:0]);
    end

    // Fetch sequencer with registered outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state         <= S_GAP;
            pc            <= {RESET_PC[31:2], 2'b00};
            buffer        <= '0;
            o_bus_request <= 1'b0;
            o_tag         <= '0;
            o_pc          <= '0;
            o_instruction <= '0;
        end else if (emit_valid) begin
            o_instruction <= emit_word;
            o_pc          <= pc;
            o_tag         <= o_tag + TAG_SIZE'(1);
            o_bus_request <= 1'b0;
            if (emit_is_jump) begin
                state <= S_WAIT_JUMP;
            end else begin
                pc    <= pc + 32'd4;
                state <= S_GAP;
            end
        end else begin
            case (state)
                S_GAP: begin
                    o_bus_request <= 1'b1;
                    state         <= S_FETCH;
                end
                S_FETCH: begin
                    // Ready while stalled: the read completes regardless.
                    if (i_bus_ready) begin
                        buffer        <= i_bus_rdata;
                        o_bus_request <= 1'b0;
                        state         <= S_HOLD;
                    end
                end
                S_WAIT_JUMP: begin
                    if (i_jump_tag == o_tag) begin
                        pc    <= {i_jump_pc[31:2], 2'b00};
                        state <= S_GAP;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_fetch.sv
// Directed bench for cpu_fetch: a bus responder with programmable latency and
// response budget, a scoreboard of expected emissions, and a monitor that pops
// the scoreboard whenever o_tag changes.
module tb_cpu_fetch;
    import cpu_fetch_pkg::*;

    logic                i_clock;
    logic                i_reset;
    logic                i_stall;
    logic                o_bus_request;
    logic                i_bus_ready;
    logic [31:0]         o_bus_address;
    logic [31:0]         i_bus_rdata;
    logic [TAG_SIZE-1:0] i_jump_tag;
    logic [31:0]         i_jump_pc;
    logic [TAG_SIZE-1:0] o_tag;
    logic [31:0]         o_instruction;
    logic [31:0]         o_pc;

    cpu_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_stall       (i_stall),
        .o_bus_request (o_bus_request),
        .i_bus_ready   (i_bus_ready),
        .o_bus_address (o_bus_address),
        .i_bus_rdata   (i_bus_rdata),
        .i_jump_tag    (i_jump_tag),
        .i_jump_pc     (i_jump_pc),
        .o_tag         (o_tag),
        .o_instruction (o_instruction),
        .o_pc          (o_pc)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    typedef struct {
        logic [TAG_SIZE-1:0] tag;
        logic [31:0]         pc;
        logic [31:0]         instr;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int emit_count = 0;
    int cycle = 0;
    int latency = 0;
    int budget = 0;
    bit force_ready = 0;
    bit jal_en = 0;
    bit check_spacing = 0;

    // Memory image: ADDI x0,x0,<addr> everywhere, JAL at 0x104 and 0x200 when enabled.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (jal_en && (a == 32'h104 || a == 32'h200))
            return 32'h0080_006F;
        return {a[11:0], 20'h00013};
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge i_clock);
    endtask

    task automatic push_exp(input logic [TAG_SIZE-1:0] tag, input logic [31:0] pc);
        exp_t e;
        e.tag   = tag;
        e.pc    = pc;
        e.instr = mem_word(pc);
        sb.push_back(e);
    endtask

    task automatic wait_req(input string name, input int max);
        int k = 0;
        while (o_bus_request !== 1'b1 && k < max) begin
            tick(1);
            k++;
        end
        check(name, {31'd0, o_bus_request}, 32'd1);
    endtask

    task automatic wait_emits(input string name, input int target, input int max);
        int k = 0;
        while (emit_count < target && k < max) begin
            tick(1);
            k++;
        end
        check(name, emit_count, target);
    endtask

    // Holds reset for three edges (with spurious ready), checks reset values, releases.
    task automatic do_reset(input int lat, input int bud, input bit spacing);
        i_reset     = 1'b1;
        force_ready = 1'b1;
        tick(3);
        check("rst_tag", {28'd0, o_tag}, 32'd0);
        check("rst_pc", o_pc, 32'd0);
        check("rst_instr", o_instruction, 32'd0);
        check("rst_req", {31'd0, o_bus_request}, 32'd0);
        sb.delete();
        emit_count    = 0;
        latency       = lat;
        budget        = bud;
        check_spacing = spacing;
        i_reset       = 1'b0;
        force_ready   = 1'b0;
    endtask

    // Bus responder: ready after `latency` request cycles, limited by `budget`.
    initial begin
        int age = 0;
        i_bus_ready = 1'b0;
        i_bus_rdata = '0;
        forever begin
            @(negedge i_clock);
            if (force_ready) begin
                i_bus_ready = 1'b1;
                i_bus_rdata = 32'h0BAD_0013;
                age = 0;
            end else if (o_bus_request) begin
                if (age >= latency && budget > 0) begin
                    i_bus_ready = 1'b1;
                    i_bus_rdata = mem_word(o_bus_address);
                    budget--;
                end else begin
                    i_bus_ready = 1'b0;
                end
                age++;
            end else begin
                i_bus_ready = 1'b0;
                age = 0;
            end
        end
    end

    // Emission monitor: a change of o_tag pops and checks one scoreboard entry.
    initial begin
        logic [TAG_SIZE-1:0] prev_tag;
        logic [31:0] prev_pc, prev_instr;
        int last_cycle = 0;
        bit have_last = 0;
        prev_tag = '0;
        prev_pc = '0;
        prev_instr = '0;
        forever begin
            @(negedge i_clock);
            cycle++;
            if (i_reset) begin
                have_last = 0;
            end else if (o_tag !== prev_tag) begin
                emit_count++;
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_emission observed tag=%h pc=%h expected none", o_tag, o_pc);
                end
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("emit_tag", {28'd0, o_tag}, {28'd0, e.tag});
                    check("emit_pc", o_pc, e.pc);
                    check("emit_instr", o_instruction, e.instr);
                end
                if (check_spacing && have_last)
                    check("emit_spacing", cycle - last_cycle, 32'd2);
                last_cycle = cycle;
                have_last  = 1;
            end else begin
                check("pc_stable", o_pc, prev_pc);
                check("instr_stable", o_instruction, prev_instr);
            end
            prev_tag   = o_tag;
            prev_pc    = o_pc;
            prev_instr = o_instruction;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset    = 1'b1;
        i_stall    = 1'b0;
        i_jump_tag = 4'hA;
        i_jump_pc  = '0;

        // Zero-wait sequential fetch; a matching jump tag outside WAIT_JUMP is inert.
        i_jump_tag = 4'h1;
        i_jump_pc  = 32'h0000_0500;
        do_reset(0, 3, 1);
        push_exp(4'h1, 32'h100);
        push_exp(4'h2, 32'h104);
        push_exp(4'h3, 32'h108);
        tick(1);
        check("first_req", {31'd0, o_bus_request}, 32'd1);
        check("first_addr", o_bus_address, 32'h100);
        tick(1);
        check("seq_tag1", {28'd0, o_tag}, 32'd1);
        tick(2);
        check("seq_tag2", {28'd0, o_tag}, 32'd2);
        tick(2);
        check("seq_tag3", {28'd0, o_tag}, 32'd3);
        check("seq_drained", sb.size(), 32'd0);
        i_jump_tag = 4'hA;

        // Ready delayed three cycles: request and address held for four cycles.
        do_reset(3, 2, 0);
        push_exp(4'h1, 32'h100);
        push_exp(4'h2, 32'h104);
        wait_emits("lat_emit1", 1, 20);
        wait_req("lat_req2", 10);
        for (int i = 0; i < 4; i++) begin
            check("lat_req_held", {31'd0, o_bus_request}, 32'd1);
            check("lat_addr_held", o_bus_address, 32'h104);
            check("lat_tag_held", {28'd0, o_tag}, 32'd1);
            tick(1);
        end
        check("lat_tag2", {28'd0, o_tag}, 32'd2);
        check("lat_req_drop", {31'd0, o_bus_request}, 32'd0);
        tick(4);
        check("lat_one_emit", emit_count, 32'd2);

        // Stall across the bus response: word buffered, emitted when stall drops.
        do_reset(0, 1, 0);
        i_stall = 1'b1;
        push_exp(4'h1, 32'h100);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("stall_tag", {28'd0, o_tag}, 32'd0);
        end
        check("stall_req_dropped", {31'd0, o_bus_request}, 32'd0);
        i_stall = 1'b0;
        tick(1);
        check("stall_release_tag", {28'd0, o_tag}, 32'd1);
        check("stall_drained", sb.size(), 32'd0);

        // Control transfers: JAL at 0x104 (tag 2) and at 0x200 (tag 4).
        jal_en = 1'b1;
        do_reset(0, 5, 0);
        push_exp(4'h1, 32'h100);
        push_exp(4'h2, 32'h104);
        wait_emits("jal1_emit", 2, 20);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("jal1_no_req", {31'd0, o_bus_request}, 32'd0);
        end
        push_exp(4'h3, 32'h1FC);
        push_exp(4'h4, 32'h200);
        i_jump_tag = 4'h2;
        i_jump_pc  = 32'h0000_01FF;
        wait_emits("jal2_emit", 4, 30);
        i_jump_tag = 4'h3;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("jal2_no_req", {31'd0, o_bus_request}, 32'd0);
        end
        push_exp(4'h5, 32'h208);
        i_jump_tag = 4'h4;
        i_jump_pc  = 32'h0000_020B;
        wait_req("jal2_req", 10);
        check("jal2_target", o_bus_address, 32'h208);
        wait_emits("jal2_target_emit", 5, 10);
        check("jal_drained", sb.size(), 32'd0);
        jal_en     = 1'b0;
        i_jump_tag = 4'hA;

        // Seventeen sequential instructions: tag wraps 15 -> 0 without a hiccup.
        do_reset(0, 17, 1);
        for (int k = 0; k < 17; k++)
            push_exp(TAG_SIZE'(k + 1), 32'h100 + 32'(4 * k));
        wait_emits("wrap_emits", 17, 60);
        check("wrap_final_tag", {28'd0, o_tag}, 32'd1);
        check("wrap_drained", sb.size(), 32'd0);

        // Reset while a request is outstanding.
        do_reset(2, 2, 0);
        push_exp(4'h1, 32'h100);
        wait_emits("pend_emit1", 1, 20);
        wait_req("pend_req", 10);
        tick(1);
        i_reset     = 1'b1;
        force_ready = 1'b1;
        tick(1);
        check("pend_rst_req", {31'd0, o_bus_request}, 32'd0);
        check("pend_rst_tag", {28'd0, o_tag}, 32'd0);
        do_reset(0, 1, 0);
        push_exp(4'h1, 32'h100);
        wait_req("restart_req", 10);
        check("restart_addr", o_bus_address, 32'h100);
        wait_emits("restart_emit", 1, 10);
        check("restart_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
